wb_sram16_bridge: RTL and testbench
===================================

# wb_sram16_bridge

Wishbone-classic responder that lets the bexkat1 pipeline's data or instruction bus initiators reach an external asynchronous 16-bit SRAM. It can stand in for the on-chip dual-port RAM on one port. Each 32-bit word access becomes one or two half-word SRAM cycles with programmable wait states. It honours `sel` byte lanes and returns a single-cycle `ack_o`. Word data is big-endian: the upper half-word is stored at the even SRAM address.

## Interface

**Parameters**

- `AWIDTH`, default 15: word address width.
- `WAIT_STATES`, default 2: extra SRAM strobe cycles per half-word. Legal range is 0–15.

**Ports**

- `clk_i` in, 1: clock. All logic is on the rising edge.
- `rst_i` in, 1: reset, asynchronous, active-low.
- `cyc_i` in, 1: bus cycle.
- `stb_i` in, 1: strobe.
- `we_i` in, 1: write enable.
- `sel_i` in, 4: byte selects. `sel_i[3]` selects `dat[31:24]`.
- `adr_i` in, AWIDTH: word address.
- `dat_i` in, 32: write data.
- `dat_o` out, 32: read data. Valid while `ack_o` is high.
- `ack_o` out, 1: acknowledge. High for exactly one cycle per access.
- `sram_addr` out, AWIDTH+1: half-word address, `{adr_i, half}`.
- `sram_dq_o` out, 16: SRAM write data.
- `sram_dq_oe` out, 1: enables the top-level tristate on the SRAM data bus.
- `sram_dq_i` in, 16: SRAM read data.
- `sram_ce_n`, `sram_oe_n`, `sram_we_n` out, 1 each: active-low chip enable, output enable, write enable.
- `sram_ub_n`, `sram_lb_n` out, 1 each: active-low upper and lower byte enables.

## Operation

**State machine:** IDLE, STROBE, RECOVER, ACK.

**IDLE**
- When `cyc_i & stb_i` is high, latch `adr_i`, `we_i`, `sel_i` and `dat_i`.
- Select the first half: half 0 if `sel_i[3:2]` is nonzero, otherwise half 1.
- If `sel_i` is 4'b0000, go directly to ACK.
- Otherwise go to STROBE.

**STROBE**
- Drive `sram_ce_n`=0 and `sram_addr`={adr,half}.
- Byte enables:
  - half 0: `ub_n`=~sel[3], `lb_n`=~sel[2]
  - half 1: `ub_n`=~sel[1], `lb_n`=~sel[0]
- Read: `oe_n`=0.
- Write: `we_n`=0, `dq_oe`=1, `dq_o` = the selected data half.
- Stay in STROBE for `WAIT_STATES`+1 cycles, timed by a 4-bit down-counter.
- On a read, capture `sram_dq_i` into the half's data register on the last STROBE cycle.

**RECOVER** (1 cycle)
- `ce_n`, `oe_n` and `we_n` are 1.
- `dq_oe` stays as in STROBE and `dq_o` is held, giving write hold time.
- If half 0 was just done and `sel[1:0]` is nonzero, set half=1 and go to STROBE.
- Otherwise go to ACK.

**ACK**
- `ack_o`=1 and `dat_o` = the captured halves. Unselected halves read as 0.
- Writes return `dat_o`=0.
- Next state is IDLE.

**Abort**
- If `cyc_i` falls while in STROBE, the current half still completes its full strobe and recover.
- The machine then returns to IDLE with no `ack_o` and skips any remaining half.
- Write strobes are never truncated.

## Timing

- **Reset values:** `ack_o`=0, `dat_o`=0, `sram_addr`=0, `sram_dq_o`=0, `sram_dq_oe`=0. `sram_ce_n`, `sram_oe_n`, `sram_we_n`, `sram_ub_n` and `sram_lb_n` are all 1. State is IDLE.
- **Reset mid-access:** all of the above take effect immediately, asynchronously.
- **Registered outputs:** every output comes directly from a register. Nothing combinational runs from the bus inputs to the SRAM pins.
- **Latency:** counted from the edge that samples `cyc_i & stb_i` in IDLE to the cycle in which `ack_o` is high.
  - Two halves: 2·(W+2)+1 cycles; 9 cycles for W=2.
  - One half: (W+2)+1 cycles; 5 cycles for W=2.
  - `sel`=0: 1 cycle.
- **Back-to-back requests:** the earliest next request is sampled in IDLE on the cycle after ACK. A held `cyc_i & stb_i` is treated as a new request.
- **Initiator rules:** the initiator holds `adr`, `dat`, `sel` and `we` until `ack_o`. The bridge uses its latched copies regardless.

## Configuration

**`WB_SRAM_SELSKIP_EN`**
- **Defined:** halves whose `sel` bits are both zero are skipped. Latency is as given in the Timing section.
- **Undefined:**
  - Both halves are always strobed, in order half 0 then half 1.
  - A half whose `sel` bits are zero is strobed with `ub_n`=`lb_n`=1; no write occurs and its read data is forced to 0.
  - Latency is always 2·(W+2)+1 cycles, including `sel`=0.

## Test plan

1. **Word write then read:** W=2, write 0x12345678 to word 0x10 with `sel`=F, then read word 0x10.
   - SRAM receives 0x1234 at address 0x20 and 0x5678 at address 0x21.
   - Each write has a `we_n` low pulse of 3 cycles.
   - `ack_o` arrives 9 cycles after each request is sampled.
   - The read returns `dat_o`=0x12345678.
2. **Byte write:** `sel`=4'b0010 with `dat_i`=0x0000AB00 to word 3.
   - With the macro defined: one strobe at address 7 with `ub_n`=0 and `lb_n`=1; ack after 5 cycles.
   - With the macro undefined: ack after 9 cycles, and the half-0 strobe has both byte enables high.
3. **Empty select:** `sel`=0 with the macro defined.
   - `ack_o` at cycle 1.
   - `sram_ce_n` never goes low.
4. **Abort:** drop `cyc_i` during the first STROBE of a word write.
   - The full 3-cycle `we_n` pulse completes.
   - Half 1 is never strobed and `ack_o` stays 0.
5. **Reset mid-access:** pull `rst_i` low during the half-1 read strobe.
   - `ce_n`, `oe_n` and `we_n` go high and `ack_o`=0 immediately.
   - After release, a new read completes normally.
6. **Zero wait states:** W=0, back-to-back reads of words 0 and 1, with `cyc_i` held.
   - Each read acks after 5 cycles.
   - The second request is sampled on the cycle after the first ack.

Source files
------------

// File: rtl/wb_sram16_bridge.sv
// rtl/wb_sram16_bridge.sv - Wishbone-classic responder bridging 32-bit word accesses to a 16-bit async SRAM
//
// Optional feature macro: WB_SRAM_SELSKIP_EN (skip half-words whose byte selects are both zero).
//
// Ports:
//   clk_i, rst_i                  clock, asynchronous active-low reset
//   cyc_i, stb_i, we_i, sel_i,
//   adr_i, dat_i                  Wishbone request (word address, big-endian word data)
//   dat_o, ack_o                  Wishbone response (single-cycle ack)
//   sram_addr                     half-word address {adr, half}
//   sram_dq_o, sram_dq_oe         SRAM write data and tristate enable
//   sram_dq_i                     SRAM read data
//   sram_ce_n, sram_oe_n,
//   sram_we_n, sram_ub_n,
//   sram_lb_n                     active-low SRAM strobes and byte enables
module wb_sram16_bridge #(
    parameter int AWIDTH      = 15,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cyc_i,
    input  logic              stb_i,
    input  logic              we_i,
    input  logic [3:0]        sel_i,
    input  logic [AWIDTH-1:0] adr_i,
    input  logic [31:0]       dat_i,
    output logic [31:0]       dat_o,
    output logic              ack_o,
    output logic [AWIDTH:0]   sram_addr,
    output logic [15:0]       sram_dq_o,
    output logic              sram_dq_oe,
    input  logic [15:0]       sram_dq_i,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              sram_ub_n,
    output logic              sram_lb_n
);

`ifdef WB_SRAM_SELSKIP_EN
    localparam bit SELSKIP = 1'b1;
`else
    localparam bit SELSKIP = 1'b0;
`endif

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STROBE  = 2'd1,
        RECOVER = 2'd2,
        ACK     = 2'd3
    } state_t;

    state_t            state;
    logic [AWIDTH-1:0] adr_q;
    logic              we_q;
    logic [3:0]        sel_q;
    logic [31:0]       dat_q;
    logic              half;
    logic [3:0]        wait_cnt;
    logic              abort_q;
    logic [15:0]       rd_hi;
    logic [15:0]       rd_lo;

    // Half 0 carries the upper (big-endian) half-word.
    function automatic logic [1:0] half_be_n(input logic [3:0] sel, input logic h);
        return h ? ~sel[1:0] : ~sel[3:2];
    endfunction

    function automatic logic [15:0] half_data(input logic [31:0] d, input logic h);
        return h ? d[15:0] : d[31:16];
    endfunction

    logic start_half;
    logic skip_all;
    logic more_half;
    logic half_live;

    assign start_half = SELSKIP && (sel_i[3:2] == 2'b00);
    assign skip_all   = SELSKIP && (sel_i == 4'b0000);
    assign more_half  = !half && (!SELSKIP || (sel_q[1:0] != 2'b00));
    // A half with no selected bytes still gets strobed when skipping is off; its data reads as zero.
    assign half_live  = half ? (sel_q[1:0] != 2'b00) : (sel_q[3:2] != 2'b00);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= IDLE;
            adr_q      <= '0;
            we_q       <= 1'b0;
            sel_q      <= 4'b0000;
            dat_q      <= 32'h0;
            half       <= 1'b0;
            wait_cnt   <= 4'h0;
            abort_q    <= 1'b0;
            rd_hi      <= 16'h0;
            rd_lo      <= 16'h0;
            dat_o      <= 32'h0;
            ack_o      <= 1'b0;
            sram_addr  <= '0;
            sram_dq_o  <= 16'h0;
            sram_dq_oe <= 1'b0;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_ub_n  <= 1'b1;
            sram_lb_n  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    ack_o <= 1'b0;
                    dat_o <= 32'h0;
                    if (cyc_i && stb_i) begin
                        adr_q   <= adr_i;
                        we_q    <= we_i;
                        sel_q   <= sel_i;
                        dat_q   <= dat_i;
                        abort_q <= 1'b0;
                        rd_hi   <= 16'h0;
                        rd_lo   <= 16'h0;
                        if (skip_all) begin
                            state <= ACK;
                            ack_o <= 1'b1;
                        end else begin
                            state                  <= STROBE;
                            half                   <= start_half;
                            wait_cnt               <= WAIT_LOAD;
                            sram_addr              <= {adr_i, start_half};
                            sram_ce_n              <= 1'b0;
                            sram_oe_n              <= we_i;
                            sram_we_n              <= ~we_i;
                            sram_dq_oe             <= we_i;
                            sram_dq_o              <= we_i ? half_data(dat_i, start_half) : 16'h0;
                            {sram_ub_n, sram_lb_n} <= half_be_n(sel_i, start_half);
                        end
                    end
                end

                STROBE: begin
                    // Dropping cyc never truncates the strobe; it only cancels what follows.
                    if (!cyc_i) begin
                        abort_q <= 1'b1;
                    end
                    if (wait_cnt == 4'h0) begin
                        if (!we_q) begin
                            if (half) begin
                                rd_lo <= half_live ? sram_dq_i : 16'h0;
                            end else begin
                                rd_hi <= half_live ? sram_dq_i : 16'h0;
                            end
                        end
                        state     <= RECOVER;
                        sram_ce_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                        sram_we_n <= 1'b1;
                        sram_ub_n <= 1'b1;
                        sram_lb_n <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 4'h1;
                    end
                end

                RECOVER: begin
                    // dq_oe and dq_o stay put through this cycle for write hold time.
                    if (abort_q) begin
                        state      <= IDLE;
                        sram_dq_oe <= 1'b0;
                    end else if (more_half) begin
                        state                  <= STROBE;
                        half                   <= 1'b1;
                        wait_cnt               <= WAIT_LOAD;
                        sram_addr              <= {adr_q, 1'b1};
                        sram_ce_n              <= 1'b0;
                        sram_oe_n              <= we_q;
                        sram_we_n              <= ~we_q;
                        sram_dq_oe             <= we_q;
                        sram_dq_o              <= we_q ? dat_q[15:0] : 16'h0;
                        {sram_ub_n, sram_lb_n} <= ~sel_q[1:0];
                    end else begin
                        state      <= ACK;
                        ack_o      <= 1'b1;
                        dat_o      <= we_q ? 32'h0 : {rd_hi, rd_lo};
                        sram_dq_oe <= 1'b0;
                    end
                end

                ACK: begin
                    state <= IDLE;
                    ack_o <= 1'b0;
                    dat_o <= 32'h0;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_sram16_bridge.sv
// tb/tb_wb_sram16_bridge.sv - randomized self-checking bench for wb_sram16_bridge against a word-level memory model
module tb_wb_sram16_bridge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [14:0] adr = '0;
    logic [31:0] wdat = 32'h0;
    logic        use0 = 1'b0;

    logic [15:0] sram_dq_i;

    logic [31:0] a_dat, b_dat;
    logic        a_ack, b_ack;
    logic [15:0] a_addr, b_addr;
    logic [15:0] a_dq_o, b_dq_o;
    logic        a_dq_oe, b_dq_oe;
    logic        a_ce_n, b_ce_n, a_oe_n, b_oe_n, a_we_n, b_we_n;
    logic        a_ub_n, b_ub_n, a_lb_n, b_lb_n;

    always #5 clk = ~clk;

    wb_sram16_bridge #(.AWIDTH(15), .WAIT_STATES(2)) u_dut_w2 (
        .clk_i(clk), .rst_i(rst_n), .cyc_i(cyc & ~use0), .stb_i(stb & ~use0),
        .we_i(we), .sel_i(sel), .adr_i(adr), .dat_i(wdat),
        .dat_o(a_dat), .ack_o(a_ack), .sram_addr(a_addr), .sram_dq_o(a_dq_o),
        .sram_dq_oe(a_dq_oe), .sram_dq_i(sram_dq_i), .sram_ce_n(a_ce_n),
        .sram_oe_n(a_oe_n), .sram_we_n(a_we_n), .sram_ub_n(a_ub_n), .sram_lb_n(a_lb_n)
    );

    wb_sram16_bridge #(.AWIDTH(15), .WAIT_STATES(0)) u_dut_w0 (
        .clk_i(clk), .rst_i(rst_n), .cyc_i(cyc & use0), .stb_i(stb & use0),
        .we_i(we), .sel_i(sel), .adr_i(adr), .dat_i(wdat),
        .dat_o(b_dat), .ack_o(b_ack), .sram_addr(b_addr), .sram_dq_o(b_dq_o),
        .sram_dq_oe(b_dq_oe), .sram_dq_i(sram_dq_i), .sram_ce_n(b_ce_n),
        .sram_oe_n(b_oe_n), .sram_we_n(b_we_n), .sram_ub_n(b_ub_n), .sram_lb_n(b_lb_n)
    );

    wire [31:0] m_dat   = use0 ? b_dat   : a_dat;
    wire        m_ack   = use0 ? b_ack   : a_ack;
    wire [15:0] m_addr  = use0 ? b_addr  : a_addr;
    wire [15:0] m_dq_o  = use0 ? b_dq_o  : a_dq_o;
    wire        m_dq_oe = use0 ? b_dq_oe : a_dq_oe;
    wire        m_ce_n  = use0 ? b_ce_n  : a_ce_n;
    wire        m_oe_n  = use0 ? b_oe_n  : a_oe_n;
    wire        m_we_n  = use0 ? b_we_n  : a_we_n;
    wire        m_ub_n  = use0 ? b_ub_n  : a_ub_n;
    wire        m_lb_n  = use0 ? b_lb_n  : a_lb_n;

    // Behavioural SRAM on the selected bridge's pins, plus the reference image it must track.
    logic [15:0] mem [0:255];
    logic [15:0] ref_mem [0:255];

    assign sram_dq_i = (!m_ce_n && !m_oe_n) ? mem[m_addr[7:0]] : 16'hDEAD;

    int          checks = 0;
    int          errors = 0;
    int          we_cycles = 0;
    int          oe_viol = 0;
    logic        prev_ce = 1'b1;
    logic [15:0] strobe_addr [$];
    logic [1:0]  strobe_be [$];

    always @(negedge clk) begin
        if (!m_ce_n && !m_we_n) begin
            if (!m_dq_oe) oe_viol++;
            if (!m_ub_n) mem[m_addr[7:0]][15:8] = m_dq_o[15:8];
            if (!m_lb_n) mem[m_addr[7:0]][7:0]  = m_dq_o[7:0];
        end
        if (!m_we_n) we_cycles++;
        if (!m_ce_n && prev_ce) begin
            strobe_addr.push_back(m_addr);
            strobe_be.push_back({m_ub_n, m_lb_n});
        end
        prev_ce = m_ce_n;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int halves_for(input logic [3:0] s);
`ifdef WB_SRAM_SELSKIP_EN
        return int'(s[3:2] != 2'b00) + int'(s[1:0] != 2'b00);
`else
        return 2;
`endif
    endfunction

    function automatic int cur_w();
        return use0 ? 0 : 2;
    endfunction

    task automatic clear_mon();
        we_cycles = 0;
        strobe_addr.delete();
        strobe_be.delete();
    endtask

    // One Wishbone access; latency is counted from the sampling edge to the ack cycle.
    task automatic access(input logic w, input logic [3:0] s, input logic [14:0] a,
                          input logic [31:0] d, input bit keep);
        int          n;
        int          nh;
        int          idx;
        logic [31:0] exp_rd;
        @(negedge clk);
        clear_mon();
        cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = a; wdat = d;
        idx = int'(a) * 2;
        nh = halves_for(s);
        exp_rd = {(s[3:2] != 2'b00) ? ref_mem[idx] : 16'h0,
                  (s[1:0] != 2'b00) ? ref_mem[idx + 1] : 16'h0};
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!m_ack && n < 80);
        check("ack_seen", 32'(m_ack), 32'd1);
        check("latency", n, (nh == 0) ? 1 : nh * (cur_w() + 2) + 1);
        check("dat_o", m_dat, w ? 32'h0 : exp_rd);
        check("strobes", strobe_addr.size(), nh);
        check("we_cycles", we_cycles, w ? nh * (cur_w() + 1) : 0);
        if (!keep) begin
            cyc = 1'b0; stb = 1'b0;
        end
        if (w) begin
            if (s[3]) ref_mem[idx][15:8]     = d[31:24];
            if (s[2]) ref_mem[idx][7:0]      = d[23:16];
            if (s[1]) ref_mem[idx + 1][15:8] = d[15:8];
            if (s[0]) ref_mem[idx + 1][7:0]  = d[7:0];
        end
    endtask

    initial begin
        int n;
        logic [14:0] ra;

        for (int i = 0; i < 256; i++) begin
            mem[i] = 16'h0;
            ref_mem[i] = 16'h0;
        end

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ack", 32'(a_ack), 32'd0);
        check("rst_dat", a_dat, 32'h0);
        check("rst_addr", 32'(a_addr), 32'h0);
        check("rst_dq", {15'h0, a_dq_oe, a_dq_o}, 32'h0);
        check("rst_ctl", {27'h0, a_ce_n, a_oe_n, a_we_n, a_ub_n, a_lb_n}, 32'h1f);
        check("rst_ctl_w0", {27'h0, b_ce_n, b_oe_n, b_we_n, b_ub_n, b_lb_n}, 32'h1f);
        rst_n = 1'b1;

        // Word write then read at W=2
        access(1'b1, 4'hF, 15'h10, 32'h12345678, 1'b0);
        check("t1_addr0", 32'(strobe_addr[0]), 32'h20);
        check("t1_addr1", 32'(strobe_addr[1]), 32'h21);
        check("t1_mem_hi", 32'(mem[8'h20]), 32'h1234);
        check("t1_mem_lo", 32'(mem[8'h21]), 32'h5678);
        access(1'b0, 4'hF, 15'h10, 32'h0, 1'b0);

        // Byte write to word 3, lane 1
        access(1'b1, 4'b0010, 15'h3, 32'h0000AB00, 1'b0);
`ifdef WB_SRAM_SELSKIP_EN
        check("t2_addr", 32'(strobe_addr[0]), 32'h7);
        check("t2_be", 32'(strobe_be[0]), 32'b01);
`else
        check("t2_addr0", 32'(strobe_addr[0]), 32'h6);
        check("t2_be0", 32'(strobe_be[0]), 32'b11);
        check("t2_be1", 32'(strobe_be[1]), 32'b01);
`endif
        check("t2_mem", 32'(mem[8'h7]), 32'hAB00);
        check("t2_mem_even", 32'(mem[8'h6]), 32'h0);

        // Empty select
        access(1'b0, 4'h0, 15'h5, 32'h0, 1'b0);

        // Abort during the first write strobe
        @(negedge clk);
        clear_mon();
        cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = 15'h20; wdat = 32'hCAFEF00D;
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_ack) n++;
        end
        check("abort_ack", n, 0);
        check("abort_we", we_cycles, 3);
        check("abort_strobes", strobe_addr.size(), 1);
        ref_mem[8'h40] = 16'hCAFE;
        check("abort_mem_hi", 32'(mem[8'h40]), 32'hCAFE);
        check("abort_mem_lo", 32'(mem[8'h41]), 32'h0);

        // Reset during the half-1 read strobe
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 15'h10;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(!m_ce_n && m_addr[0]) && n < 40);
        check("rst_mid_reached", 32'(n < 40), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_ctl", {29'h0, m_ce_n, m_oe_n, m_we_n}, 32'h7);
        check("rst_mid_ack", 32'(m_ack), 32'd0);
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        access(1'b0, 4'hF, 15'h10, 32'h0, 1'b0);

        // Zero wait states, back-to-back reads with cyc held
        use0 = 1'b1;
        access(1'b1, 4'hF, 15'h0, 32'hA5A55A5A, 1'b0);
        access(1'b1, 4'hF, 15'h1, 32'h0BADBEEF, 1'b0);
        access(1'b0, 4'hF, 15'h0, 32'h0, 1'b1);
        access(1'b0, 4'hF, 15'h1, 32'h0, 1'b0);

        // Randomized traffic on both bridges
        for (int i = 0; i < 60; i++) begin
            use0 = 1'($urandom_range(0, 1));
            ra = 15'($urandom_range(0, 15));
            access(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), ra, $urandom, 1'b0);
        end

        for (int i = 0; i < 64; i++) begin
            if (mem[i] !== ref_mem[i]) begin
                check($sformatf("mem_img[%0d]", i), 32'(mem[i]), 32'(ref_mem[i]));
            end
        end
        check("mem_img_all", 32'(mem[8'h20]), 32'(ref_mem[8'h20]));
        check("dq_oe_during_write", oe_viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
